clock_mode_ctrl: RTL and testbench

Top-level mode sequencer for the digital clock. It turns raw button levels into single-cycle pulses, decides whether the clock is running, editing time, editing the alarm, or ringing, and routes the button pulses to the active editor. When an editor acknowledges, the block issues a one-cycle load strobe so the timekeeper or alarm register captures the edited value. It sits between the button synchronizers and the time/alarm editors, timekeeper and buzzer driver.

---
 rtl/clock_mode_ctrl.sv | 137 +++++++++++++
 tb/tb_clock_mode_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_mode_ctrl.sv
// Mode sequencer for the digital clock: button edge detection, RUN/SET_TIME/
// SET_ALARM/RING sequencing, press routing to editors and load strobes.
module clock_mode_ctrl #(
    parameter int IDLE_TIMEOUT = 30,
    parameter int RING_SECONDS = 60,
    parameter int CNT_W        = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic       set_btn,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       set_ack,
    input  logic       alarm_ack,
    input  logic       alarm_match,
    output logic       set_time_en,
    output logic       set_alarm_en,
    output logic       mode_pulse,
    output logic       inc_pulse,
    output logic       time_load,
    output logic       alarm_load,
    output logic       alarm_armed,
    output logic       buzzer,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SET_TIME  = 2'd1,
        SET_ALARM = 2'd2,
        RING      = 2'd3
    } state_t;

    // Timeouts fire on the tick that would bring the count to the limit.
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_SECONDS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           cur;
    state_t           nxt;
    logic [CNT_W-1:0] cnt;
    logic             set_prev;
    logic             mode_prev;
    logic             inc_prev;
    logic             match_prev;

    logic set_p;
    logic mode_p;
    logic inc_p;
    logic any_p;
    logic match_rise;
    logic idle_done;
    logic ring_done;
    logic editing;

    assign set_p      = set_btn & ~set_prev;
    assign mode_p     = mode_btn & ~mode_prev;
    assign inc_p      = inc_btn & ~inc_prev;
    assign any_p      = set_p | mode_p | inc_p;
    assign match_rise = alarm_match & ~match_prev;
    assign idle_done  = sec_tick && (cnt >= IDLE_LAST);
    assign ring_done  = sec_tick && (cnt >= RING_LAST);
    assign editing    = (cur == SET_TIME) || (cur == SET_ALARM);
    assign state      = cur;

    always_comb begin
        nxt = cur;
        case (cur)
            RUN: begin
                if (set_p)
                    nxt = SET_TIME;
                else if (match_rise && alarm_armed)
                    nxt = RING;
            end
            SET_TIME: begin
                if (set_ack)
                    nxt = RUN;
                else if (set_p)
                    nxt = SET_ALARM;
                else if (idle_done)
                    nxt = RUN;
            end
            SET_ALARM: begin
                if (alarm_ack || set_p || idle_done)
                    nxt = RUN;
            end
            RING: begin
                if (any_p || ring_done)
                    nxt = RUN;
            end
            default: nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur          <= RUN;
            cnt          <= '0;
            set_prev     <= 1'b0;
            mode_prev    <= 1'b0;
            inc_prev     <= 1'b0;
            match_prev   <= 1'b0;
            set_time_en  <= 1'b0;
            set_alarm_en <= 1'b0;
            mode_pulse   <= 1'b0;
            inc_pulse    <= 1'b0;
            time_load    <= 1'b0;
            alarm_load   <= 1'b0;
            alarm_armed  <= 1'b0;
            buzzer       <= 1'b0;
        end else begin
            set_prev   <= set_btn;
            mode_prev  <= mode_btn;
            inc_prev   <= inc_btn;
            match_prev <= alarm_match;
            cur        <= nxt;

            // A press beats a same-cycle tick; the count saturates instead of wrapping.
            if ((nxt != cur) || any_p)
                cnt <= '0;
            else if (sec_tick && (cur != RUN) && (cnt != CNT_MAX))
                cnt <= cnt + 1'b1;

            set_time_en  <= (nxt == SET_TIME);
            set_alarm_en <= (nxt == SET_ALARM);
            buzzer       <= (nxt == RING);
            mode_pulse   <= mode_p && editing;
            inc_pulse    <= inc_p && editing;
            time_load    <= (cur == SET_TIME) && set_ack;
            alarm_load   <= (cur == SET_ALARM) && alarm_ack;
            if ((cur == SET_ALARM) && alarm_ack)
                alarm_armed <= 1'b1;
        end
    end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl: a scoreboard checks every output pulse,
// and level outputs are checked at fixed points of the stimulus.
module tb_clock_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       sec_tick, set_btn, mode_btn, inc_btn;
    logic       set_ack, alarm_ack, alarm_match;
    logic       set_time_en, set_alarm_en, mode_pulse, inc_pulse;
    logic       time_load, alarm_load, alarm_armed, buzzer;
    logic [1:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    // Pulse vector order: {mode_pulse, inc_pulse, time_load, alarm_load}
    localparam logic [3:0] EV_MODE  = 4'b1000;
    localparam logic [3:0] EV_INC   = 4'b0100;
    localparam logic [3:0] EV_TLOAD = 4'b0010;
    localparam logic [3:0] EV_ALOAD = 4'b0001;

    logic [3:0] exp_q[$];

    clock_mode_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .sec_tick     (sec_tick),
        .set_btn      (set_btn),
        .mode_btn     (mode_btn),
        .inc_btn      (inc_btn),
        .set_ack      (set_ack),
        .alarm_ack    (alarm_ack),
        .alarm_match  (alarm_match),
        .set_time_en  (set_time_en),
        .set_alarm_en (set_alarm_en),
        .mode_pulse   (mode_pulse),
        .inc_pulse    (inc_pulse),
        .time_load    (time_load),
        .alarm_load   (alarm_load),
        .alarm_armed  (alarm_armed),
        .buzzer       (buzzer),
        .state        (state)
    );

    always #5 clk = ~clk;

    // Pulse monitor: every cycle with any pulse high must match the next queued event.
    always @(negedge clk) begin
        logic [3:0] got;
        logic [3:0] want;
        got = {mode_pulse, inc_pulse, time_load, alarm_load};
        if (got != 4'b0000) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL pulse_unexpected: got %b, required none at %0t", got, $time);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL pulse_event: got %b, required %b at %0t", got, want, $time);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sec(input int n);
        for (int i = 0; i < n; i++) begin
            sec_tick = 1'b1;
            tick();
            sec_tick = 1'b0;
            tick();
        end
    endtask

    task automatic press_set();
        set_btn = 1'b1; tick(); set_btn = 1'b0; tick();
    endtask

    task automatic press_inc();
        inc_btn = 1'b1; tick(); inc_btn = 1'b0; tick();
    endtask

    initial begin
        rst = 1'b0;
        sec_tick = 0; set_ack = 0; alarm_ack = 0; alarm_match = 0;
        set_btn = 1; mode_btn = 1; inc_btn = 1;
        repeat (3) tick();
        chk("reset_state", state, 2'd0);
        chk("reset_outs", {set_time_en | set_alarm_en | buzzer | alarm_armed,
                           mode_pulse | inc_pulse | time_load | alarm_load}, 2'b00);

        // Release with buttons held: no forwarded pulses; SET edge enters SET_TIME.
        rst = 1'b1;
        tick(); tick();
        chk("release_no_pulse", {mode_pulse, inc_pulse}, 2'b00);
        set_btn = 0; mode_btn = 0; inc_btn = 0;
        tick();
        press_set();
        press_set();
        chk("back_to_run", state, 2'd0);

        // Time edit
        press_set();
        chk("set_time_state", state, 2'd1);
        chk("set_time_en", {1'b0, set_time_en}, 2'd1);
        repeat (3) begin
            exp_q.push_back(EV_INC);
            press_inc();
        end
        exp_q.push_back(EV_TLOAD);
        set_ack = 1'b1;
        tick();
        chk("tload_first", {1'b0, time_load}, 2'd1);
        chk("tload_state", state, 2'd0);
        tick();
        chk("tload_one_cycle", {1'b0, time_load}, 2'd0);
        chk("set_time_en_off", {1'b0, set_time_en}, 2'd0);
        set_ack = 1'b0;
        tick();

        // Alarm commit and ring
        press_set();
        press_set();
        chk("set_alarm_state", state, 2'd2);
        chk("set_alarm_en", {1'b0, set_alarm_en}, 2'd1);
        exp_q.push_back(EV_ALOAD);
        alarm_ack = 1'b1;
        tick();
        alarm_ack = 1'b0;
        chk("armed", {1'b0, alarm_armed}, 2'd1);
        chk("after_aload", state, 2'd0);
        tick();
        alarm_match = 1'b1;
        tick();
        chk("ring_state", state, 2'd3);
        chk("ring_buzzer", {1'b0, buzzer}, 2'd1);
        press_inc();
        chk("ring_cancel", state, 2'd0);
        chk("ring_cancel_buzz", {1'b0, buzzer}, 2'd0);
        alarm_match = 1'b0;
        tick();

        // Idle timeout after 30 ticks
        press_set();
        sec(29);
        chk("timeout_29", state, 2'd1);
        sec(1);
        chk("timeout_30", state, 2'd0);

        // MODE press on tick 20 restarts the count: timeout on tick 50
        press_set();
        sec(19);
        exp_q.push_back(EV_MODE);
        mode_btn = 1'b1; sec_tick = 1'b1;
        tick();
        mode_btn = 1'b0; sec_tick = 1'b0;
        tick();
        sec(29);
        chk("timeout_49", state, 2'd1);
        sec(1);
        chk("timeout_50", state, 2'd0);

        // Reset mid-edit clears armed, no load
        press_set();
        rst = 1'b0;
        tick();
        chk("midreset_state", state, 2'd0);
        chk("midreset_armed", {1'b0, alarm_armed}, 2'd0);
        rst = 1'b1;
        tick();

        // Unarmed match does not ring
        alarm_match = 1'b1;
        tick(); tick();
        chk("unarmed_no_ring", state, 2'd0);
        alarm_match = 1'b0;
        tick();

        // Arm, ring, expire after 60 ticks, no re-ring on held match
        press_set();
        press_set();
        exp_q.push_back(EV_ALOAD);
        alarm_ack = 1'b1;
        tick();
        alarm_ack = 1'b0;
        tick();
        alarm_match = 1'b1;
        tick();
        chk("ring2_state", state, 2'd3);
        sec(59);
        chk("ring_59_buzz", {1'b0, buzzer}, 2'd1);
        sec(1);
        chk("ring_60_buzz", {1'b0, buzzer}, 2'd0);
        chk("ring_60_state", state, 2'd0);
        sec(3);
        chk("no_rering", state, 2'd0);
        alarm_match = 1'b0;
        tick();

        // Ack beats SET press in SET_TIME
        press_set();
        exp_q.push_back(EV_TLOAD);
        set_ack = 1'b1; set_btn = 1'b1;
        tick();
        chk("prio_tload", {1'b0, time_load}, 2'd1);
        chk("prio_state", state, 2'd0);
        set_ack = 1'b0; set_btn = 1'b0;
        tick(); tick();

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_pulses: got %0d outstanding, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
